// File: rtl/cnn_layer_accel_weight_seq_gen_pkg.sv
// Shared types, default sequence tables and width helpers for the weight-address sequencer.
package cnn_layer_accel_wht_seq_pkg;

    localparam int DEF_KERNEL_SIZE = 3;
    localparam int DEF_NUM_SEQ     = 4;
    localparam int DEF_SEQ_LEN     = 5;
    localparam int DEF_REP_W       = 8;
    localparam int DEF_ADDR_W      = $clog2(DEF_KERNEL_SIZE * DEF_KERNEL_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Tap orders of the original fixed 3x3 four-sequence table.
    localparam int unsigned LEGACY_SEQ [4][5] = '{
        '{0, 2, 6, 7, 8},
        '{0, 1, 6, 7, 8},
        '{0, 2, 3, 4, 5},
        '{0, 1, 3, 4, 5}
    };

    function automatic int unsigned default_seq(input int k, input int num_seq, input int seq_len,
                                                input int s, input int i);
        if (k == 3 && num_seq == 4 && seq_len == 5 && s >= 0 && s < 4 && i >= 0 && i < 5)
            return LEGACY_SEQ[s[1:0]][i[2:0]];
        return 0;
    endfunction

    function automatic logic [1:0] gray_sel_to_seq_id(input logic [1:0] gray_code, input logic sel);
        return {gray_code[1] ^ gray_code[0], ~sel};
    endfunction

endpackage

// File: rtl/cnn_layer_accel_weight_seq_gen_if.sv
// Weight-address stream: valid/ready handshake carrying a tap index and an end-of-stream flag.
interface cnn_layer_accel_weight_seq_gen_if #(
    parameter int ADDR_W = cnn_layer_accel_wht_seq_pkg::DEF_ADDR_W
);
    logic              wht_valid;
    logic              wht_ready;
    logic [ADDR_W-1:0] wht_data_addr;
    logic              wht_last;

    modport master (output wht_valid, output wht_data_addr, output wht_last, input wht_ready);
    modport slave  (input wht_valid, input wht_data_addr, input wht_last, output wht_ready);
endinterface

// File: rtl/cnn_layer_accel_weight_seq_gen_ram.sv
// Sequence register file: NUM_SEQ x SEQ_LEN tap indices plus per-table lengths, reset to defaults.
module cnn_layer_accel_wht_seq_ram
    import cnn_layer_accel_wht_seq_pkg::*;
#(
    parameter int KERNEL_SIZE = 3,
    parameter int NUM_SEQ     = 4,
    parameter int SEQ_LEN     = 5,
    parameter int ADDR_W      = 4,
    parameter int ID_W        = 2,
    parameter int IDX_W       = 3,
    parameter int LEN_W       = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ID_W-1:0]   wr_seq,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_data,
    input  logic              len_wr_en,
    input  logic [LEN_W-1:0]  len_wr_data,
    input  logic [ID_W-1:0]   rd_seq,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_data,
    output logic [LEN_W-1:0]  rd_len
);

    logic [ADDR_W-1:0] tbl   [NUM_SEQ][SEQ_LEN];
    logic [LEN_W-1:0]  len_q [NUM_SEQ];
    logic [LEN_W-1:0]  len_clamped;

    always_comb begin
        len_clamped = len_wr_data;
        if (len_wr_data == '0)
            len_clamped = LEN_W'(1);
        else if (int'(len_wr_data) > SEQ_LEN)
            len_clamped = LEN_W'(SEQ_LEN);
    end

    // NOTE: this storage is tiny and must come back to known taps on reset, so it is
    // built from resettable flops rather than an inferred RAM macro.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SEQ; s++) begin
                len_q[s] <= LEN_W'(SEQ_LEN);
                for (int i = 0; i < SEQ_LEN; i++)
                    tbl[s][i] <= ADDR_W'(default_seq(KERNEL_SIZE, NUM_SEQ, SEQ_LEN, s, i));
            end
        end else begin
            if (wr_en && int'(wr_idx) < SEQ_LEN)
                tbl[wr_seq][wr_idx] <= wr_data;
            if (len_wr_en)
                len_q[wr_seq] <= len_clamped;
        end
    end

    assign rd_data = tbl[rd_seq][rd_idx];
    assign rd_len  = len_q[rd_seq];

endmodule

// File: rtl/cnn_layer_accel_weight_seq_gen.sv
// Weight-address sequencer top: streams a programmed tap table num_rep+1 times over valid/ready.
// Optional sticky config-error flag enabled by CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN.
module cnn_layer_accel_weight_seq_gen
    import cnn_layer_accel_wht_seq_pkg::*;
#(
    parameter  int KERNEL_SIZE = 3,
    parameter  int NUM_SEQ     = 4,
    parameter  int SEQ_LEN     = 5,
    parameter  int REP_W       = 8,
    localparam int ADDR_W      = $clog2(KERNEL_SIZE * KERNEL_SIZE),
    localparam int ID_W        = $clog2(NUM_SEQ),
    localparam int IDX_W       = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1,
    localparam int LEN_W       = $clog2(SEQ_LEN + 1)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_wr_en,
    input  logic [ID_W-1:0]   cfg_seq_id,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_data,
    input  logic              cfg_len_wr_en,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    input  logic [ID_W-1:0]   seq_id,
    input  logic [REP_W-1:0]  num_rep,
    output logic              busy,
    cnn_layer_accel_weight_seq_gen_if.master wht,
    output logic              done
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN
    ,
    output logic              cfg_err
`endif
);

    state_e            state;
    logic [ID_W-1:0]   sid;
    logic [REP_W-1:0]  rep_max;
    logic [IDX_W-1:0]  idx;
    logic [REP_W:0]    rep;
    logic              valid_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;

    logic [ID_W-1:0]   rd_seq;
    logic [IDX_W-1:0]  rd_idx;
    logic [REP_W:0]    rd_rep;
    logic [REP_W-1:0]  rd_rep_max;
    logic [ADDR_W-1:0] rd_data;
    logic [LEN_W-1:0]  rd_len;
    logic              at_end_of_seq;
    logic              fetch_last;
    logic [IDX_W-1:0]  nxt_idx;
    logic [REP_W:0]    nxt_rep;
    logic              hs;

    cnn_layer_accel_wht_seq_ram #(
        .KERNEL_SIZE (KERNEL_SIZE),
        .NUM_SEQ     (NUM_SEQ),
        .SEQ_LEN     (SEQ_LEN),
        .ADDR_W      (ADDR_W),
        .ID_W        (ID_W),
        .IDX_W       (IDX_W),
        .LEN_W       (LEN_W)
    ) u_ram (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (cfg_wr_en),
        .wr_seq      (cfg_seq_id),
        .wr_idx      (cfg_idx),
        .wr_data     (cfg_data),
        .len_wr_en   (cfg_len_wr_en),
        .len_wr_data (cfg_len),
        .rd_seq      (rd_seq),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_len      (rd_len)
    );

    // In IDLE the first entry is fetched straight from the start inputs so valid rises next cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_seq     = sid;
        rd_idx     = idx;
        rd_rep     = rep;
        rd_rep_max = rep_max;
        if (state == ST_IDLE) begin
            rd_seq     = seq_id;
            rd_idx     = '0;
            rd_rep     = '0;
            rd_rep_max = num_rep;
        end
        at_end_of_seq = (LEN_W'(rd_idx) + LEN_W'(1)) >= rd_len;
        fetch_last    = at_end_of_seq && (rd_rep == {1'b0, rd_rep_max});
        nxt_idx       = at_end_of_seq ? '0 : rd_idx + IDX_W'(1);
        nxt_rep       = at_end_of_seq ? rd_rep + {{REP_W{1'b0}}, 1'b1} : rd_rep;
    end

    assign hs = valid_q && wht.wht_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            sid     <= '0;
            rep_max <= '0;
            idx     <= '0;
            rep     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        sid     <= seq_id;
                        rep_max <= num_rep;
                        addr_q  <= rd_data;
                        last_q  <= fetch_last;
                        valid_q <= 1'b1;
                        idx     <= nxt_idx;
                        rep     <= nxt_rep;
                    end
                end
                ST_RUN: begin
                    if (hs && last_q) begin
                        state   <= ST_DONE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (!valid_q || wht.wht_ready) begin
                        addr_q  <= rd_data;
                        last_q  <= fetch_last;
                        valid_q <= 1'b1;
                        idx     <= nxt_idx;
                        rep     <= nxt_rep;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign wht.wht_valid     = valid_q;
    assign wht.wht_data_addr = addr_q;
    assign wht.wht_last      = last_q;

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN
    // Out-of-range taps and rewrites of the table being streamed are flagged; data is still written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cfg_err <= 1'b0;
        else if ((cfg_wr_en && int'(cfg_data) >= KERNEL_SIZE * KERNEL_SIZE) ||
                 ((cfg_wr_en || cfg_len_wr_en) && busy && cfg_seq_id == sid))
            cfg_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_gen.sv
// Scoreboard bench for cnn_layer_accel_weight_seq_gen; expected streams come from a table model.
`timescale 1ns/1ps
module tb_cnn_layer_accel_weight_seq_gen;
    import cnn_layer_accel_wht_seq_pkg::*;

    localparam int K  = 3;
    localparam int NS = 4;
    localparam int SL = 5;
    localparam int RW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_wr_en = 1'b0;
    logic [1:0]    cfg_seq_id = '0;
    logic [2:0]    cfg_idx = '0;
    logic [AW-1:0] cfg_data = '0;
    logic          cfg_len_wr_en = 1'b0;
    logic [2:0]    cfg_len = '0;
    logic          start = 1'b0;
    logic [1:0]    seq_id = '0;
    logic [RW-1:0] num_rep = '0;
    logic          busy;
    logic          done;
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN
    logic          cfg_err;
`endif

    always #5 clk = ~clk;

    cnn_layer_accel_weight_seq_gen_if #(.ADDR_W(AW)) wht ();

    cnn_layer_accel_weight_seq_gen #(
        .KERNEL_SIZE (K),
        .NUM_SEQ     (NS),
        .SEQ_LEN     (SL),
        .REP_W       (RW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr_en     (cfg_wr_en),
        .cfg_seq_id    (cfg_seq_id),
        .cfg_idx       (cfg_idx),
        .cfg_data      (cfg_data),
        .cfg_len_wr_en (cfg_len_wr_en),
        .cfg_len       (cfg_len),
        .start         (start),
        .seq_id        (seq_id),
        .num_rep       (num_rep),
        .busy          (busy),
        .wht           (wht),
        .done          (done)
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN
        ,
        .cfg_err       (cfg_err)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    exp_t sb [$];
    int   m_tbl [NS][SL];
    int   m_len [NS];
    int   total = 0;
    int   bad   = 0;
    int   hs_count = 0;
    int   ready_mode = 0;
    bit   done_seen = 1'b0;
    bit   expect_done = 1'b0;
    bit   hold_pending = 1'b0;
    logic [AW-1:0] held_addr;
    logic          held_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tbl = '{'{0, 2, 6, 7, 8}, '{0, 1, 6, 7, 8}, '{0, 2, 3, 4, 5}, '{0, 1, 3, 4, 5}};
        for (int s = 0; s < NS; s++) m_len[s] = SL;
    endtask

    task automatic cfg_write(input int s, input int i, input int d);
        @(posedge clk); #1;
        cfg_wr_en = 1'b1; cfg_seq_id = 2'(s); cfg_idx = 3'(i); cfg_data = AW'(d);
        @(posedge clk); #1;
        cfg_wr_en = 1'b0;
        if (i < SL) m_tbl[s][i] = d;
    endtask

    task automatic len_write(input int s, input int l);
        @(posedge clk); #1;
        cfg_len_wr_en = 1'b1; cfg_seq_id = 2'(s); cfg_len = 3'(l);
        @(posedge clk); #1;
        cfg_len_wr_en = 1'b0;
        m_len[s] = (l == 0) ? 1 : (l > SL) ? SL : l;
    endtask

    // The stream is num_rep+1 passes over the active prefix of the table.
    task automatic begin_stream(input int s, input int rep, input int mode);
        exp_t e;
        for (int r = 0; r <= rep; r++)
            for (int i = 0; i < m_len[s]; i++) begin
                e.addr = AW'(m_tbl[s][i]);
                e.last = (r == rep) && (i == m_len[s] - 1);
                sb.push_back(e);
            end
        done_seen  = 1'b0;
        ready_mode = mode;
        @(posedge clk); #1;
        seq_id = 2'(s); num_rep = RW'(rep); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("first_valid_latency", 32'(wht.wht_valid), 1);
        check("busy_on_accept", 32'(busy), 1);
    endtask

    task automatic finish_stream();
        int n;
        n = 0;
        while (!done_seen && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("stream_done", 32'(done_seen), 1);
        check("sb_drained", 32'(sb.size()), 0);
        @(posedge clk);
    endtask

    initial begin
        wht.wht_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       wht.wht_ready = 1'b1;
                1:       wht.wht_ready = ~wht.wht_ready;
                default: wht.wht_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks holds under backpressure and done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_pending = 1'b0;
                expect_done  = 1'b0;
                continue;
            end
            if (expect_done) begin
                check("done_pulse", 32'(done), 1);
                check("busy_in_done", 32'(busy), 0);
                check("valid_in_done", 32'(wht.wht_valid), 0);
                expect_done = 1'b0;
                done_seen   = 1'b1;
            end else begin
                check("done_idle", 32'(done), 0);
            end
            if (hold_pending) begin
                check("hold_valid", 32'(wht.wht_valid), 1);
                check("hold_addr", 32'(wht.wht_data_addr), 32'(held_addr));
                check("hold_last", 32'(wht.wht_last), 32'(held_last));
                hold_pending = 1'b0;
            end
            if (wht.wht_valid && wht.wht_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'(wht.wht_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("addr", 32'(wht.wht_data_addr), 32'(e.addr));
                    check("last", 32'(wht.wht_last), 32'(e.last));
                    if (e.last) expect_done = 1'b1;
                end
                hs_count++;
            end else if (wht.wht_valid) begin
                hold_pending = 1'b1;
                held_addr    = wht.wht_data_addr;
                held_last    = wht.wht_last;
            end
        end
    end

    initial begin
        int s, base, n;
        model_reset();
        #3;
        check("rst_valid", 32'(wht.wht_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_last", 32'(wht.wht_last), 0);
        check("rst_addr", 32'(wht.wht_data_addr), 0);
`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN
        check("rst_cfg_err", 32'(cfg_err), 0);
`endif
        #9 rst = 1'b1;

        for (int g = 0; g < 4; g++)
            for (int sl = 0; sl < 2; sl++)
                check("gray_map", 32'(gray_sel_to_seq_id(2'(g), 1'(sl))),
                      32'(((g ^ (g >> 1)) & 1) * 2 + (1 - sl)));

        begin_stream(0, 0, 0); finish_stream();
        begin_stream(3, 1, 1); finish_stream();

        len_write(1, 2);
        cfg_write(1, 0, 4);
        cfg_write(1, 1, 7);
        cfg_write(1, 5, 3);
        cfg_write(1, 7, 1);
        begin_stream(1, 2, 0); finish_stream();
        len_write(2, 0);
        begin_stream(2, 1, 2); finish_stream();
        len_write(2, 7);
        begin_stream(2, 0, 1); finish_stream();

        begin_stream(0, 1, 0);
        @(posedge clk); #1;
        start = 1'b1; seq_id = 2'd2; num_rep = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ignores_start", 32'(busy), 1);
        finish_stream();

        len_write(3, 1);
        begin_stream(3, 255, 0); finish_stream();
        len_write(3, 5);

        for (int it = 0; it < 6; it++) begin
            s = int'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 1) == 1)
                cfg_write(s, int'($urandom_range(0, SL - 1)), int'($urandom_range(0, K * K - 1)));
            if ($urandom_range(0, 2) == 0)
                len_write(s, int'($urandom_range(0, 7)));
            begin_stream(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 2)));
            finish_stream();
        end

        base = hs_count;
        begin_stream(1, 3, 0);
        n = 0;
        while (hs_count < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_mid_stream_reached", 32'(hs_count >= base + 2), 1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(wht.wht_valid), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_last", 32'(wht.wht_last), 0);
        check("async_rst_addr", 32'(wht.wht_data_addr), 0);
        check("async_rst_done", 32'(done), 0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        begin_stream(1, 0, 0); finish_stream();

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN
        check("err_before_bad_write", 32'(cfg_err), 0);
        cfg_write(0, 0, 9);
        check("err_set", 32'(cfg_err), 1);
        begin_stream(0, 0, 0); finish_stream();
        check("err_sticky", 32'(cfg_err), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_weight_seq_gen.md
Name: cnn_layer_accel_weight_seq_gen

Overview:
Parametrised weight-address sequencer for the CNN layer accelerator's convolution engine. It holds NUM_SEQ programmable sequence tables of kernel-tap indices and, on a start handshake, streams one table's entries as weight-buffer addresses under valid/ready flow control. The stream repeats a programmable number of times. It generalises the fixed 3x3, four-sequence, single-lookup weight sequence table.

Parameters:
KERNEL_SIZE, 3, kernel width/height; legal tap indices are 0..KERNEL_SIZE*KERNEL_SIZE-1
NUM_SEQ, 4, number of sequence tables (power of 2, >=2)
SEQ_LEN, 5, maximum entries per sequence
REP_W, 8, width of the repeat count
ADDR_W, clog2(KERNEL_SIZE*KERNEL_SIZE), tap-index width (derived; do not override)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
cfg_wr_en  in  1  table write strobe
cfg_seq_id  in  clog2(NUM_SEQ)  table to write
cfg_idx  in  clog2(SEQ_LEN)  entry to write
cfg_data  in  ADDR_W  tap index to write
cfg_len_wr_en  in  1  length write strobe
cfg_len  in  clog2(SEQ_LEN+1)  active length of cfg_seq_id (1..SEQ_LEN)
start  in  1  request to begin a stream
seq_id  in  clog2(NUM_SEQ)  table to stream; sampled when start is accepted
num_rep  in  REP_W  stream is emitted num_rep+1 times; sampled when start is accepted
busy  out  1  high from accept until done
wht_valid  out  1  output address valid
wht_ready  in  1  consumer ready
wht_data_addr  out  ADDR_W  weight tap index
wht_last  out  1  final entry of the final repetition
done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, wht_valid, wht_last, done=0; wht_data_addr=0.
- Reset table contents come from pkg function default_seq. For K=3/NUM_SEQ=4/SEQ_LEN=5: seq0={0,2,6,7,8}, seq1={0,1,6,7,8}, seq2={0,2,3,4,5}, seq3={0,1,3,4,5}, all lengths=5. For any other parameter set: all entries 0, lengths=SEQ_LEN.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> RUN, busy=1; latch seq_id and num_rep; clear idx and rep counters. start is ignored outside IDLE.
  - RUN: output register loads table[sid][idx] whenever !wht_valid || wht_ready.
    - First wht_valid rises the cycle after accept (latency 1).
    - Handshake = wht_valid&&wht_ready. On each handshake idx increments.
    - When idx reaches len-1, idx wraps to 0 and rep increments.
    - wht_last=1 alongside the entry with idx=len-1 and rep=num_rep.
    - While wht_valid && !wht_ready, wht_data_addr and wht_last hold stable.
  - Handshake with wht_last -> DONE. DONE: wht_valid=0, done=1 for one cycle, busy=0, -> IDLE.
  - A new start is accepted only in the cycle after DONE, when the FSM is back in IDLE.
- Config writes are accepted in any state.
  - A write to the active sid during RUN takes effect at the next table read; no stall.
  - cfg_len=0 is clamped to 1; cfg_len>SEQ_LEN is clamped to SEQ_LEN.
  - cfg_idx>=SEQ_LEN is ignored.
- Legacy selection mapping: pkg function gray_sel_to_seq_id(gray_code, sel) = {gray_code[1]^gray_code[0], ~sel}.
- Reset mid-stream: all outputs return to reset values immediately; table contents are restored to defaults.
- num_rep at max (all ones) emits 2^REP_W repetitions without overflow; the rep counter is REP_W+1 bits wide.

Optional Feature:
Macro CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN.
- Defined: adds output cfg_err (1 bit, sticky, cleared only by reset). It sets on a cfg_wr_en with cfg_data>=KERNEL_SIZE*KERNEL_SIZE, or on a config write to the active sid while busy. Offending data is still written.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package cnn_layer_accel_wht_seq_pkg holds:
  - FSM state enum
  - default_seq function
  - gray_sel_to_seq_id function
  - width helper constants
- One sub-module, cnn_layer_accel_wht_seq_ram: NUM_SEQ x SEQ_LEN register file plus length registers, with a write port, an async-reset default load and a combinational read.

Test Plan:
1. Reset, start seq_id=0, num_rep=0, wht_ready=1 -> addresses 0,2,6,7,8 on five consecutive cycles starting 1 cycle after start; wht_last with 8; done pulse next cycle.
2. seq_id=3, num_rep=1, ready toggling 1,0,1,0 -> 0,1,3,4,5,0,1,3,4,5; each value held while ready=0; wht_last only on the second 5.
3. Write seq1 len=2, entries {4,7}; start seq_id=1, num_rep=2 -> 4,7,4,7,4,7; cfg_len=0 write -> single-entry stream.
4. start asserted during RUN -> ignored; busy stays high; the stream is unchanged.
5. rst low mid-stream after 2 handshakes -> wht_valid=0 and busy=0 asynchronously; seq1 table restored to {0,1,6,7,8}.
6. With CNN_LAYER_ACCEL_WHT_SEQ_ERR_EN: write cfg_data=9 (K=3) -> cfg_err=1 and remains set after a subsequent complete stream.
